// File: rtl/qft_bitrev_stream_pkg.sv
// Shared definitions for the QFT bit-reversal reorder buffer: default
// fixed-point component width, bank identifiers and the index reversal helper.
package qft_bitrev_stream_pkg;

  // Width of one signed fixed-point real or imaginary component.
  localparam int TOTAL_WIDTH = 16;

  // Identifies one of the two ping-pong amplitude banks.
  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_e;

  // Reverse the low nq bits of idx; bits at and above nq come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nq);
    logic [31:0] rev;
    logic [4:0]  src;
    rev = 32'd0;
    src = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (i < nq) begin
        src = 5'(nq - 1 - i);
        rev[5'(i)] = idx[src];
      end else begin
        rev[5'(i)] = 1'b0;
      end
    end
    return rev;
  endfunction

endpackage

// File: rtl/qft_amp_bank.sv
// One amplitude bank: DEPTH complex entries, a single synchronous write port
// and a combinational read port. Contents are deliberately left unreset.
module qft_amp_bank
  import qft_bitrev_stream_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter int DATA_W = TOTAL_WIDTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata_r,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata_r,
  output logic [DATA_W-1:0] rdata_i
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] mem_i [DEPTH];

  // Store an accepted amplitude at its natural-order slot.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata_r;
      mem_i[waddr] <= wdata_i;
    end
  end

  assign rdata_r = mem_r[raddr];
  assign rdata_i = mem_i[raddr];

endmodule

// File: rtl/qft_bitrev_stream.sv
// Streaming bit-reversal reorder buffer for the QFT datapath. Amplitudes arrive
// in natural index order, fill one of two ping-pong banks, and leave in
// bit-reversed order while the other bank fills, so one amplitude per clock can
// move in each direction.
module qft_bitrev_stream
  import qft_bitrev_stream_pkg::*;
#(
  parameter int NUM_QUBITS = 3,
  parameter int DATA_W     = TOTAL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_r,
  input  logic [DATA_W-1:0]     s_i,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_W-1:0]     m_r,
  output logic [DATA_W-1:0]     m_i,
  output logic [NUM_QUBITS-1:0] m_index,
  output logic                  m_last,
  output logic                  frame_err
);

  localparam int                    N        = 1 << NUM_QUBITS;
  localparam logic [NUM_QUBITS-1:0] LAST_IDX = {NUM_QUBITS{1'b1}};
  localparam logic [NUM_QUBITS-1:0] IDX_ONE  = NUM_QUBITS'(1'b1);

  bank_e                 wr_bank_r, wr_bank_n;
  bank_e                 rd_bank_r, rd_bank_n;
  logic [NUM_QUBITS-1:0] wr_idx_r, wr_idx_n;
  logic [NUM_QUBITS-1:0] rd_idx_r, rd_idx_n;
  logic [1:0]            full_r, full_n;
  logic                  frame_err_r, frame_err_n;

  logic                  in_acc_s, out_acc_s;
  logic                  wr_at_end_s, rd_at_end_s;
  logic [NUM_QUBITS-1:0] rd_addr_s;
  logic [DATA_W-1:0]     a_r_s, a_i_s, b_r_s, b_i_s;

  // Handshakes and the bit-reversed read address.
  always_comb begin
    s_ready     = !rst && !full_r[wr_bank_r];
    m_valid     = full_r[rd_bank_r];
    in_acc_s    = s_valid && s_ready;
    out_acc_s   = m_valid && m_ready;
    wr_at_end_s = (wr_idx_r == LAST_IDX);
    rd_at_end_s = (rd_idx_r == LAST_IDX);
    rd_addr_s   = NUM_QUBITS'(bitrev({{(32-NUM_QUBITS){1'b0}}, rd_idx_r}, NUM_QUBITS));
  end

  // Output mux: selected bank entry while valid, zeros otherwise.
  always_comb begin
    m_r       = {DATA_W{1'b0}};
    m_i       = {DATA_W{1'b0}};
    m_index   = {NUM_QUBITS{1'b0}};
    m_last    = 1'b0;
    frame_err = frame_err_r;
    if (m_valid) begin
      m_index = rd_addr_s;
      m_last  = rd_at_end_s;
      if (rd_bank_r == BANK_A) begin
        m_r = a_r_s;
        m_i = a_i_s;
      end else begin
        m_r = b_r_s;
        m_i = b_i_s;
      end
    end else begin
      m_index = {NUM_QUBITS{1'b0}};
    end
  end

  // Next-state: write-side and read-side counters, bank flags, frame check.
  // A write can only complete into a non-full bank and a read only drains a
  // full one, so the set and clear of full never hit the same bank.
  always_comb begin
    wr_bank_n   = wr_bank_r;
    rd_bank_n   = rd_bank_r;
    wr_idx_n    = wr_idx_r;
    rd_idx_n    = rd_idx_r;
    full_n      = full_r;
    frame_err_n = frame_err_r;

    if (in_acc_s) begin
      if (wr_at_end_s) begin
        full_n[wr_bank_r] = 1'b1;
        wr_bank_n         = (wr_bank_r == BANK_A) ? BANK_B : BANK_A;
        wr_idx_n          = {NUM_QUBITS{1'b0}};
      end else begin
        wr_idx_n = wr_idx_r + IDX_ONE;
      end
      // s_last only flags misalignment; the frame boundary follows the count.
      if (s_last != wr_at_end_s) begin
        frame_err_n = 1'b1;
      end else begin
        frame_err_n = frame_err_r;
      end
    end else begin
      wr_idx_n = wr_idx_r;
    end

    if (out_acc_s) begin
      if (rd_at_end_s) begin
        full_n[rd_bank_r] = 1'b0;
        rd_bank_n         = (rd_bank_r == BANK_A) ? BANK_B : BANK_A;
        rd_idx_n          = {NUM_QUBITS{1'b0}};
      end else begin
        rd_idx_n = rd_idx_r + IDX_ONE;
      end
    end else begin
      rd_idx_n = rd_idx_r;
    end
  end

  // Control state register; reset discards any partial or buffered frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_r   <= BANK_A;
      rd_bank_r   <= BANK_A;
      wr_idx_r    <= {NUM_QUBITS{1'b0}};
      rd_idx_r    <= {NUM_QUBITS{1'b0}};
      full_r      <= 2'b00;
      frame_err_r <= 1'b0;
    end else begin
      wr_bank_r   <= wr_bank_n;
      rd_bank_r   <= rd_bank_n;
      wr_idx_r    <= wr_idx_n;
      rd_idx_r    <= rd_idx_n;
      full_r      <= full_n;
      frame_err_r <= frame_err_n;
    end
  end

  qft_amp_bank #(
    .DEPTH  (N),
    .AW     (NUM_QUBITS),
    .DATA_W (DATA_W)
  ) u_bank_a (
    .clk     (clk),
    .we      (in_acc_s && (wr_bank_r == BANK_A)),
    .waddr   (wr_idx_r),
    .wdata_r (s_r),
    .wdata_i (s_i),
    .raddr   (rd_addr_s),
    .rdata_r (a_r_s),
    .rdata_i (a_i_s)
  );

  qft_amp_bank #(
    .DEPTH  (N),
    .AW     (NUM_QUBITS),
    .DATA_W (DATA_W)
  ) u_bank_b (
    .clk     (clk),
    .we      (in_acc_s && (wr_bank_r == BANK_B)),
    .waddr   (wr_idx_r),
    .wdata_r (s_r),
    .wdata_i (s_i),
    .raddr   (rd_addr_s),
    .rdata_r (b_r_s),
    .rdata_i (b_i_s)
  );

endmodule

// File: tb/tb_qft_bitrev_stream.sv
// Self-checking bench for qft_bitrev_stream: a 3-qubit instance exercised by
// the main scenarios and a 2-qubit instance for the small-frame case. Expected
// amplitudes are queued when a frame's last input is accepted and popped as
// the DUT emits them.
module tb_qft_bitrev_stream;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, s_valid, s_ready, s_last, m_valid, m_ready, m_last, frame_err;
  logic [DW-1:0] s_r, s_i, m_r, m_i;
  logic [2:0]    m_index;

  logic          rst4, s_valid4, s_ready4, s_last4, m_valid4, m_ready4, m_last4, frame_err4;
  logic [DW-1:0] s_r4, s_i4, m_r4, m_i4;
  logic [1:0]    m_index4;

  qft_bitrev_stream #(.NUM_QUBITS(3), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_r(s_r), .s_i(s_i),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_r(m_r), .m_i(m_i),
    .m_index(m_index), .m_last(m_last), .frame_err(frame_err)
  );

  qft_bitrev_stream #(.NUM_QUBITS(2), .DATA_W(DW)) dut4 (
    .clk(clk), .rst(rst4), .s_valid(s_valid4), .s_ready(s_ready4), .s_r(s_r4), .s_i(s_i4),
    .s_last(s_last4), .m_valid(m_valid4), .m_ready(m_ready4), .m_r(m_r4), .m_i(m_i4),
    .m_index(m_index4), .m_last(m_last4), .frame_err(frame_err4)
  );

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] i;
    logic [2:0]  idx;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;
  int   rev8[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int   rev4[4] = '{0, 2, 1, 3};

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Drive the 3-qubit input side; imaginary part is the negated real part.
  task automatic drive(input logic sv, input logic [15:0] r, input logic sl, input logic mr);
    s_valid = sv;
    s_r     = r;
    s_i     = -r;
    s_last  = sl;
    m_ready = mr;
    #1;
  endtask

  task automatic push_frame(input logic [15:0] base);
    exp_t        e;
    logic [15:0] v;
    for (int j = 0; j < 8; j++) begin
      v      = base + 16'(rev8[j]);
      e.r    = v;
      e.i    = -v;
      e.idx  = 3'(rev8[j]);
      e.last = (j == 7);
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    tick();
    tick();
    checks++;
    if (s_ready !== 1'b0) begin
      errors++; $display("FAIL reset_s_ready_low: got %b, want 0", s_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_s_ready_high: got %b, want 1", s_ready);
    end
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0) begin
      errors++; $display("FAIL reset_m_valid: got valid=%b last=%b, want 0 0", m_valid, m_last);
    end
    checks++;
    if (m_r !== 16'h0 || m_i !== 16'h0 || m_index !== 3'd0) begin
      errors++; $display("FAIL reset_outputs: got r=%h i=%h idx=%0d, want zeros", m_r, m_i, m_index);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_frame_err: got %b, want 0", frame_err);
    end
  endtask

  task automatic test_natural();
    exp_t e;
    int k = 0, nout = 0, budget = 0, last_acc = -100, first_val = -1;
    while (nout < 8 && budget < 60) begin
      drive(k < 8, 16'(k), k == 7, 1'b1);
      if (m_valid && first_val < 0) first_val = cycle;
      if (m_valid && m_ready) begin
        nout++; checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL nat_extra: got r=%h, want no output", m_r);
        end else begin
          e = sb.pop_front();
          if ({m_r, m_i, m_index, m_last} !== {e.r, e.i, e.idx, e.last}) begin
            errors++;
            $display("FAIL nat_out[%0d]: got r=%h i=%h idx=%0d last=%b, want r=%h i=%h idx=%0d last=%b",
                     nout-1, m_r, m_i, m_index, m_last, e.r, e.i, e.idx, e.last);
          end
        end
      end
      if (s_valid && s_ready) begin
        if (k == 7) begin
          push_frame(16'h0);
          last_acc = cycle;
        end
        k++;
      end
      tick();
      budget++;
    end
    checks++;
    if (nout != 8) begin
      errors++; $display("FAIL nat_count: got %0d outputs, want 8", nout);
    end
    checks++;
    if (first_val != last_acc + 1) begin
      errors++; $display("FAIL nat_latency: got first valid at cycle %0d, want %0d", first_val, last_acc + 1);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++; $display("FAIL nat_frame_err: got %b, want 0", frame_err);
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [15:0] base;
    int k = 0, nout = 0, budget = 0, drops = 0, gaps = 0;
    while (nout < 24 && budget < 80) begin
      base = 16'h100 * 16'(k / 8 + 1);
      drive(k < 24, base + 16'(k % 8), (k % 8) == 7, 1'b1);
      if (k < 24 && !s_ready) drops++;
      if (nout > 0 && !m_valid) gaps++;
      if (m_valid && m_ready) begin
        nout++; checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL b2b_extra: got r=%h, want no output", m_r);
        end else begin
          e = sb.pop_front();
          if ({m_r, m_i, m_index, m_last} !== {e.r, e.i, e.idx, e.last}) begin
            errors++;
            $display("FAIL b2b_out[%0d]: got r=%h i=%h idx=%0d last=%b, want r=%h i=%h idx=%0d last=%b",
                     nout-1, m_r, m_i, m_index, m_last, e.r, e.i, e.idx, e.last);
          end
        end
      end
      if (s_valid && s_ready) begin
        if ((k % 8) == 7) push_frame(base);
        k++;
      end
      tick();
      budget++;
    end
    checks++;
    if (nout != 24) begin
      errors++; $display("FAIL b2b_count: got %0d outputs, want 24", nout);
    end
    checks++;
    if (drops != 0) begin
      errors++; $display("FAIL b2b_s_ready: got %0d not-ready cycles, want 0", drops);
    end
    checks++;
    if (gaps != 0) begin
      errors++; $display("FAIL b2b_gaps: got %0d idle output cycles, want 0", gaps);
    end
  endtask

  task automatic test_backpressure();
    exp_t        e;
    logic [15:0] base;
    int k = 0, nout = 0, budget = 0;
    while (k < 16 && budget < 60) begin
      base = 16'h400 + 16'h100 * 16'(k / 8);
      drive(1'b1, base + 16'(k % 8), (k % 8) == 7, 1'b0);
      if (s_valid && s_ready) begin
        if ((k % 8) == 7) push_frame(base);
        k++;
      end
      tick();
      budget++;
    end
    checks++;
    if (k != 16) begin
      errors++; $display("FAIL bp_accepts: got %0d accepts, want 16", k);
    end
    for (int h = 0; h < 3; h++) begin
      drive(1'b0, 16'h0, 1'b0, 1'b0);
      checks++;
      if (s_ready !== 1'b0) begin
        errors++; $display("FAIL bp_s_ready_low[%0d]: got %b, want 0", h, s_ready);
      end
      checks++;
      if ({m_valid, m_r, m_i, m_index, m_last} !== {1'b1, 16'h400, 16'hFC00, 3'd0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b r=%h i=%h idx=%0d last=%b, want 1 0400 fc00 0 0",
                 h, m_valid, m_r, m_i, m_index, m_last);
      end
      tick();
    end
    budget = 0;
    while (nout < 16 && budget < 60) begin
      drive(1'b0, 16'h0, 1'b0, 1'b1);
      if (nout == 8) begin
        checks++;
        if (s_ready !== 1'b1) begin
          errors++; $display("FAIL bp_s_ready_free: got %b, want 1", s_ready);
        end
      end
      if (m_valid && m_ready) begin
        nout++; checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL bp_extra: got r=%h, want no output", m_r);
        end else begin
          e = sb.pop_front();
          if ({m_r, m_i, m_index, m_last} !== {e.r, e.i, e.idx, e.last}) begin
            errors++;
            $display("FAIL bp_out[%0d]: got r=%h i=%h idx=%0d last=%b, want r=%h i=%h idx=%0d last=%b",
                     nout-1, m_r, m_i, m_index, m_last, e.r, e.i, e.idx, e.last);
          end
        end
      end
      tick();
      budget++;
    end
    checks++;
    if (nout != 16) begin
      errors++; $display("FAIL bp_count: got %0d outputs, want 16", nout);
    end
  endtask

  task automatic test_reset_midframe();
    exp_t e;
    int k = 0, nout = 0, budget = 0;
    while (k < 5 && budget < 20) begin
      drive(1'b1, 16'h55 + 16'(k), 1'b0, 1'b1);
      if (s_valid && s_ready) k++;
      tick();
      budget++;
    end
    rst = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++; $display("FAIL mid_rst_state: got s_ready=%b m_valid=%b, want 1 0", s_ready, m_valid);
    end
    k = 0;
    budget = 0;
    while ((nout < 8 || budget < 16) && budget < 60) begin
      drive(k < 8, 16'd10 + 16'(k), k == 7, 1'b1);
      if (m_valid && m_ready) begin
        nout++; checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL mid_extra: got r=%h, want no output", m_r);
        end else begin
          e = sb.pop_front();
          if ({m_r, m_i, m_index, m_last} !== {e.r, e.i, e.idx, e.last}) begin
            errors++;
            $display("FAIL mid_out[%0d]: got r=%h i=%h idx=%0d last=%b, want r=%h i=%h idx=%0d last=%b",
                     nout-1, m_r, m_i, m_index, m_last, e.r, e.i, e.idx, e.last);
          end
        end
      end
      if (s_valid && s_ready) begin
        if (k == 7) push_frame(16'd10);
        k++;
      end
      tick();
      budget++;
    end
    checks++;
    if (nout != 8) begin
      errors++; $display("FAIL mid_count: got %0d outputs, want 8", nout);
    end
  endtask

  task automatic test_misaligned();
    exp_t e;
    logic exp_err;
    int k = 0, nout = 0, budget = 0;
    while (nout < 8 && budget < 60) begin
      drive(k < 8, 16'h30 + 16'(k), k == 3, 1'b1);
      exp_err = (k > 3);
      checks++;
      if (frame_err !== exp_err) begin
        errors++; $display("FAIL mis_frame_err[k=%0d]: got %b, want %b", k, frame_err, exp_err);
      end
      if (m_valid && m_ready) begin
        nout++; checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL mis_extra: got r=%h, want no output", m_r);
        end else begin
          e = sb.pop_front();
          if ({m_r, m_i, m_index, m_last} !== {e.r, e.i, e.idx, e.last}) begin
            errors++;
            $display("FAIL mis_out[%0d]: got r=%h i=%h idx=%0d last=%b, want r=%h i=%h idx=%0d last=%b",
                     nout-1, m_r, m_i, m_index, m_last, e.r, e.i, e.idx, e.last);
          end
        end
      end
      if (s_valid && s_ready) begin
        if (k == 7) push_frame(16'h30);
        k++;
      end
      tick();
      budget++;
    end
    checks++;
    if (nout != 8 || frame_err !== 1'b1) begin
      errors++; $display("FAIL mis_end: got %0d outputs frame_err=%b, want 8 1", nout, frame_err);
    end
  endtask

  task automatic test_two_qubits();
    exp_t e;
    int k = 0, nout = 0, budget = 0;
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    #1;
    checks++;
    if (s_ready4 !== 1'b1 || m_valid4 !== 1'b0) begin
      errors++; $display("FAIL q2_reset: got s_ready=%b m_valid=%b, want 1 0", s_ready4, m_valid4);
    end
    while (nout < 4 && budget < 40) begin
      s_valid4 = (k < 4);
      s_r4     = 16'h20 + 16'(k);
      s_i4     = -(16'h20 + 16'(k));
      s_last4  = (k == 3);
      m_ready4 = 1'b1;
      #1;
      if (m_valid4 && m_ready4) begin
        nout++; checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL q2_extra: got r=%h, want no output", m_r4);
        end else begin
          e = sb.pop_front();
          if ({m_r4, m_i4, 1'b0, m_index4, m_last4} !== {e.r, e.i, e.idx, e.last}) begin
            errors++;
            $display("FAIL q2_out[%0d]: got r=%h i=%h idx=%0d last=%b, want r=%h i=%h idx=%0d last=%b",
                     nout-1, m_r4, m_i4, m_index4, m_last4, e.r, e.i, e.idx, e.last);
          end
        end
      end
      if (s_valid4 && s_ready4) begin
        if (k == 3) begin
          for (int j = 0; j < 4; j++) begin
            e.r    = 16'h20 + 16'(rev4[j]);
            e.i    = -(16'h20 + 16'(rev4[j]));
            e.idx  = 3'(rev4[j]);
            e.last = (j == 3);
            sb.push_back(e);
          end
        end
        k++;
      end
      tick();
      budget++;
    end
    checks++;
    if (nout != 4 || frame_err4 !== 1'b0) begin
      errors++; $display("FAIL q2_end: got %0d outputs frame_err=%b, want 4 0", nout, frame_err4);
    end
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_r = 16'h0; s_i = 16'h0; s_last = 1'b0; m_ready = 1'b0;
    rst4 = 1'b1; s_valid4 = 1'b0; s_r4 = 16'h0; s_i4 = 16'h0; s_last4 = 1'b0; m_ready4 = 1'b0;
    test_reset();
    test_natural();
    test_back_to_back();
    test_backpressure();
    test_reset_midframe();
    test_misaligned();
    test_two_qubits();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_empty: got %0d pending, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
